// File: rtl/teclado_senha.sv
// teclado_senha: keypad digit collector.
// Accumulates BCD digits from decoded key events into a password packet and
// hands complete entries to the lock controller with a one-cycle strobe.
module teclado_senha #(
   parameter int MAX_DIGITS     = 20,
   parameter int MIN_DIGITS     = 4,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    teclado_en,
   input  logic                    key_valid,
   input  logic [3:0]              key_code,
   output logic [4*MAX_DIGITS-1:0] digitos_value,
   output logic                    digitos_valid,
   output logic [4:0]              digit_count,
   output logic                    timeout
);

   localparam int PW = 4 * MAX_DIGITS;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [3:0] KEY_CLEAR   = 4'hA;
   localparam logic [3:0] KEY_CONFIRM = 4'hB;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_SEND
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   buf_q, buf_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [TW-1:0]   idle_q, idle_d;
   logic [PW-1:0]   value_q, value_d;
   logic            valid_q, valid_d;
   logic            tmo_q, tmo_d;
   logic            is_digit;

   assign is_digit = (key_code <= 4'd9);

   // Next-state logic: disable override first, then per-state key handling.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      idle_d  = idle_q;
      value_d = value_q;
      valid_d = 1'b0;
      tmo_d   = 1'b0;
      if (!teclado_en) begin
         // Disabled keypad discards any entry; the last packet stays visible.
         state_d = S_IDLE;
         buf_d   = '1;
         cnt_d   = '0;
         idle_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               idle_d = '0;
               if (key_valid && is_digit) begin
                  // Buffer is all 0xF here, so shifting equals loading.
                  buf_d   = {buf_q[PW-5:0], key_code};
                  cnt_d   = 5'd1;
                  state_d = S_COLLECT;
               end
            end
            S_COLLECT: begin
               if (key_valid) begin
                  // Any key, even an ignored or dropped one, counts as activity.
                  idle_d = '0;
                  if (is_digit) begin
                     if (cnt_q < 5'(MAX_DIGITS)) begin
                        buf_d = {buf_q[PW-5:0], key_code};
                        cnt_d = cnt_q + 5'd1;
                     end
                  end else if (key_code == KEY_CLEAR) begin
                     buf_d   = '1;
                     cnt_d   = '0;
                     state_d = S_IDLE;
                  end else if (key_code == KEY_CONFIRM) begin
                     if (cnt_q >= 5'(MIN_DIGITS)) begin
                        state_d = S_SEND;
                     end else begin
                        buf_d   = '1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                     end
                  end
               end else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  buf_d   = '1;
                  cnt_d   = '0;
                  idle_d  = '0;
                  tmo_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
            S_SEND: begin
               // Keys arriving in this cycle are intentionally ignored.
               value_d = buf_q;
               valid_d = 1'b1;
               buf_d   = '1;
               cnt_d   = '0;
               idle_d  = '0;
               state_d = S_IDLE;
            end
            default: begin
               buf_d   = '1;
               cnt_d   = '0;
               idle_d  = '0;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and registered outputs, with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         buf_q   <= '1;
         cnt_q   <= '0;
         idle_q  <= '0;
         value_q <= '1;
         valid_q <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         value_q <= value_d;
         valid_q <= valid_d;
         tmo_q   <= tmo_d;
      end
   end

   assign digitos_value = value_q;
   assign digitos_valid = valid_q;
   assign digit_count   = cnt_q;
   assign timeout       = tmo_q;

endmodule

// File: tb/tb_teclado_senha.sv
// Directed testbench for teclado_senha with a shortened inactivity timeout.
module tb_teclado_senha;

   localparam int MAXD = 20;
   localparam int TOUT = 16;

   logic            clk;
   logic            rst;
   logic            teclado_en;
   logic            key_valid;
   logic [3:0]      key_code;
   logic [79:0]     digitos_value;
   logic            digitos_valid;
   logic [4:0]      digit_count;
   logic            timeout;

   int errors = 0;
   int checks = 0;
   int vcount = 0;
   int tcount = 0;

   localparam logic [79:0] ALL_F    = {80{1'b1}};
   localparam logic [79:0] PKT_1234 = 80'hFFFF_FFFF_FFFF_FFFF_1234;
   localparam logic [79:0] PKT_4321 = 80'hFFFF_FFFF_FFFF_FFFF_4321;
   localparam logic [79:0] PKT_OVF  = 80'h0123_4567_8901_2345_6789;

   teclado_senha #(
      .MAX_DIGITS     (MAXD),
      .MIN_DIGITS     (4),
      .TIMEOUT_CYCLES (TOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .teclado_en    (teclado_en),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .digitos_value (digitos_value),
      .digitos_valid (digitos_valid),
      .digit_count   (digit_count),
      .timeout       (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count strobes as seen just before each rising edge.
   always @(posedge clk) begin
      if (digitos_valid) vcount <= vcount + 1;
      if (timeout)       tcount <= tcount + 1;
   end

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One key strobe; returns at the falling edge after the sampling edge.
   task automatic press(input logic [3:0] code);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = code;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int v0;
      int t0;
      rst        = 1'b1;
      teclado_en = 1'b1;
      key_valid  = 1'b0;
      key_code   = 4'h0;
      repeat (2) @(negedge clk);
      chk("rst_value", digitos_value, ALL_F);
      chk("rst_valid", 80'(digitos_valid), 80'd0);
      chk("rst_count", 80'(digit_count), 80'd0);
      chk("rst_timeout", 80'(timeout), 80'd0);
      rst = 1'b0;

      // 1: back-to-back 1,2,3,4 then confirm; two-cycle latency.
      v0 = vcount;
      @(negedge clk); key_valid = 1'b1; key_code = 4'h1;
      @(negedge clk); key_code = 4'h2;
      @(negedge clk); key_code = 4'h3;
      @(negedge clk); key_code = 4'h4;
      @(negedge clk); key_valid = 1'b0;
      chk("t1_count4", 80'(digit_count), 80'd4);
      press(4'hB);
      chk("t1_valid_lat1", 80'(digitos_valid), 80'd0);
      @(negedge clk);
      chk("t1_valid_lat2", 80'(digitos_valid), 80'd1);
      chk("t1_value", digitos_value, PKT_1234);
      @(negedge clk);
      chk("t1_valid_width", 80'(digitos_valid), 80'd0);
      chk("t1_count0", 80'(digit_count), 80'd0);
      repeat (2) @(negedge clk);
      chk("t1_one_strobe", 80'(vcount - v0), 80'd1);

      // 2: too few digits, confirm discards silently.
      v0 = vcount;
      press(4'h1); press(4'h2); press(4'h3);
      chk("t2_count3", 80'(digit_count), 80'd3);
      press(4'hB);
      chk("t2_count0", 80'(digit_count), 80'd0);
      repeat (3) @(negedge clk);
      chk("t2_no_strobe", 80'(vcount - v0), 80'd0);
      chk("t2_value_held", digitos_value, PKT_1234);

      // 3: 22 digits, saturation at 20.
      v0 = vcount;
      for (int i = 0; i < 22; i++) press(4'(i % 10));
      chk("t3_count_sat", 80'(digit_count), 80'd20);
      press(4'hB);
      @(negedge clk);
      chk("t3_valid", 80'(digitos_valid), 80'd1);
      chk("t3_value", digitos_value, PKT_OVF);
      repeat (2) @(negedge clk);
      chk("t3_count0", 80'(digit_count), 80'd0);
      chk("t3_one_strobe", 80'(vcount - v0), 80'd1);

      // 4a: inactivity timeout after the last key.
      t0 = tcount;
      press(4'h5); press(4'h6);
      repeat (TOUT - 1) @(negedge clk);
      chk("t4_pre_timeout", 80'(timeout), 80'd0);
      chk("t4_pre_count", 80'(digit_count), 80'd2);
      @(negedge clk);
      chk("t4_timeout", 80'(timeout), 80'd1);
      chk("t4_count0", 80'(digit_count), 80'd0);
      @(negedge clk);
      chk("t4_timeout_width", 80'(timeout), 80'd0);
      chk("t4_one_pulse", 80'(tcount - t0), 80'd1);

      // 4b: key in the expiry cycle wins and restarts the counter.
      t0 = tcount;
      press(4'h5); press(4'h6);
      repeat (TOUT - 1) @(negedge clk);
      key_valid = 1'b1; key_code = 4'h7;
      @(negedge clk);
      key_valid = 1'b0;
      chk("t4b_no_timeout", 80'(timeout), 80'd0);
      chk("t4b_count3", 80'(digit_count), 80'd3);
      repeat (TOUT - 1) @(negedge clk);
      chk("t4b_restart", 80'(tcount - t0), 80'd0);
      @(negedge clk);
      chk("t4b_late_timeout", 80'(timeout), 80'd1);
      chk("t4b_count0", 80'(digit_count), 80'd0);

      // 5a: clear key, then a good entry; key during send ignored.
      v0 = vcount;
      press(4'h9); press(4'h9); press(4'hA);
      chk("t5_clear", 80'(digit_count), 80'd0);
      press(4'h1); press(4'h2); press(4'h3); press(4'h4);
      press(4'hB);
      key_valid = 1'b1; key_code = 4'h5;
      @(negedge clk);
      key_valid = 1'b0;
      chk("t5_valid", 80'(digitos_valid), 80'd1);
      chk("t5_value", digitos_value, PKT_1234);
      chk("t5_send_key_ignored", 80'(digit_count), 80'd0);
      repeat (2) @(negedge clk);
      chk("t5_one_strobe", 80'(vcount - v0), 80'd1);

      // 5b: keypad disable mid-entry discards it.
      v0 = vcount;
      press(4'h1); press(4'h2); press(4'h3); press(4'h4);
      teclado_en = 1'b0;
      @(negedge clk);
      chk("t5b_dis_count", 80'(digit_count), 80'd0);
      press(4'h8);
      chk("t5b_dis_key", 80'(digit_count), 80'd0);
      teclado_en = 1'b1;
      press(4'hB);
      repeat (3) @(negedge clk);
      chk("t5b_no_strobe", 80'(vcount - v0), 80'd0);
      chk("t5b_value_held", digitos_value, PKT_1234);

      // 6: reset mid-entry, then a fresh entry.
      v0 = vcount;
      press(4'h7); press(4'h8); press(4'h9);
      chk("t6_count3", 80'(digit_count), 80'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_rst_count", 80'(digit_count), 80'd0);
      chk("t6_rst_value", digitos_value, ALL_F);
      press(4'h4); press(4'h3); press(4'h2); press(4'h1);
      press(4'hB);
      @(negedge clk);
      chk("t6_valid", 80'(digitos_valid), 80'd1);
      chk("t6_value", digitos_value, PKT_4321);
      repeat (2) @(negedge clk);
      chk("t6_one_strobe", 80'(vcount - v0), 80'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
